// File: rtl/indata_word_packer.sv
// indata_word_packer: packs a 24-bit sample stream (4 samples -> 3 words,
// LSB-first) into 32-bit words. The words go through an output FIFO to a
// ready/valid master port. m_last marks the final word of each line.
module indata_word_packer #(
   parameter int unsigned LINE_LEN   = 256,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] data_in,
   input  logic        valid_in,
   input  logic        clr_ovf,
   output logic [31:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        line_done,
   output logic        overflow
);

   localparam int unsigned SW = $clog2(LINE_LEN);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [SW-1:0] SCNT_MAX = SW'(LINE_LEN - 1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {PH0, PH1, PH2, PH3} ph_t;

   ph_t           ph_q, ph_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic [23:0]   hold_q, hold_d;

   logic          push;
   logic [31:0]   push_data;
   logic          push_last;

   logic [32:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, push_ok, ovf_set;

   // Phase, sample counter and hold register update on accepted samples
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ph_q   <= PH0;
         scnt_q <= '0;
         hold_q <= '0;
      end else begin
         ph_q   <= ph_d;
         scnt_q <= scnt_d;
         hold_q <= hold_d;
      end
   end

   // Next phase and word assembly from the held bytes plus the incoming sample
   always_comb begin
      ph_d      = ph_q;
      scnt_d    = scnt_q;
      hold_d    = hold_q;
      push      = 1'b0;
      push_data = '0;
      push_last = 1'b0;
      if (valid_in) begin
         scnt_d = (scnt_q == SCNT_MAX) ? '0 : scnt_q + 1'b1;
         case (ph_q)
            PH0: begin
               hold_d = data_in;
               ph_d   = PH1;
            end
            PH1: begin
               push      = 1'b1;
               push_data = {data_in[7:0], hold_q};
               hold_d    = {8'h00, data_in[23:8]};
               ph_d      = PH2;
            end
            PH2: begin
               push      = 1'b1;
               push_data = {data_in[15:0], hold_q[15:0]};
               hold_d    = {16'h0000, data_in[23:16]};
               ph_d      = PH3;
            end
            PH3: begin
               push      = 1'b1;
               push_data = {data_in, hold_q[7:0]};
               push_last = (scnt_q == SCNT_MAX);
               ph_d      = PH0;
            end
         endcase
      end
   end

   assign line_done = valid_in && (scnt_q == SCNT_MAX);

   // Full is taken from the registered count. A pop in the same cycle makes room for the push.
   assign full    = (count == CNT_FULL);
   assign m_valid = (count != '0);
   assign pop     = m_valid && m_ready;
   assign push_ok = push && (!full || pop);
   assign ovf_set = push && full && !pop;

   // FIFO storage: no reset needed, because the count qualifies every read
   always_ff @(posedge clk) begin
      if (rst_n && push_ok)
         mem[wr_ptr] <= {push_last, push_data};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)
            count <= count + 1'b1;
         else if (pop && !push_ok)
            count <= count - 1'b1;
      end
   end

   // Sticky overflow flag: a new drop takes priority over a clear request
   always_ff @(posedge clk) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (ovf_set)
         overflow <= 1'b1;
      else if (clr_ovf)
         overflow <= 1'b0;
   end

   assign m_data = m_valid ? mem[rd_ptr][31:0] : '0;
   assign m_last = m_valid && mem[rd_ptr][32];

endmodule

// File: tb/tb_indata_word_packer.sv
// Directed bench for indata_word_packer. It uses a per-cycle vector table
// for reset and short packing sequences. Hand-written sequences cover the
// full-line, overflow and push-while-full cases, checked against a byte-stream model.
module tb_indata_word_packer;

   localparam int unsigned LINE_LEN   = 256;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int          WPL        = 3 * LINE_LEN / 4;

   logic        clk = 1'b0;
   logic        rst_n, valid_in, clr_ovf, m_ready;
   logic [23:0] data_in;
   logic [31:0] m_data;
   logic        m_valid, m_last, line_done, overflow;

   always #5 clk = ~clk;

   indata_word_packer #(.LINE_LEN(LINE_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
      .clr_ovf(clr_ovf), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .line_done(line_done), .overflow(overflow)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_w[$];
   logic        exp_l[$];
   logic [7:0]  bq[$];
   int          widx;
   int          got_words;

   typedef struct {
      logic        rst_n;
      logic        v;
      logic [23:0] d;
      logic        rdy;
      logic        clr;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_last;
      logic        e_ldone;
      logic        e_ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [23:0] d,
                        input logic rdy, input logic clr);
      rst_n = r; valid_in = v; data_in = d; m_ready = rdy; clr_ovf = clr;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] samp(input int i);
      logic [31:0] t;
      t = (i + 1) * 32'h0003_0507;
      return t[23:0];
   endfunction

   // Byte-stream reference model: bytes go in LSB-first and come out as little-endian words.
   task automatic expect_sample(input logic [23:0] d);
      logic [31:0] w;
      bq.push_back(d[7:0]);
      bq.push_back(d[15:8]);
      bq.push_back(d[23:16]);
      while (bq.size() >= 4) begin
         w = {bq[3], bq[2], bq[1], bq[0]};
         repeat (4) void'(bq.pop_front());
         exp_w.push_back(w);
         exp_l.push_back((widx % WPL) == WPL - 1);
         widx++;
      end
   endtask

   task automatic observe(input string tag);
      if (m_valid && m_ready) begin
         if (exp_w.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected word got=%h exp=none", tag, m_data);
         end else begin
            chk({tag, " data"}, m_data, exp_w[0]);
            chk({tag, " last"}, m_last, exp_l[0]);
            void'(exp_w.pop_front());
            void'(exp_l.pop_front());
            got_words++;
         end
      end
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         drive(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
         tick();
      end
      exp_w.delete(); exp_l.delete(); bq.delete();
      widx = 0; got_words = 0;
   endtask

   task automatic add(input logic r, input logic v, input logic [23:0] d, input logic rdy,
                      input logic ev, input logic [31:0] ed);
      tbl.push_back('{rst_n:r, v:v, d:d, rdy:rdy, clr:1'b0, e_valid:ev, e_data:ed,
                      e_last:1'b0, e_ldone:1'b0, e_ovf:1'b0});
   endtask

   task automatic add_pack_rows;
      add(1, 1, 24'h112233, 1, 0, 32'h0);
      add(1, 1, 24'h445566, 1, 0, 32'h0);
      add(1, 1, 24'h778899, 1, 1, 32'h66112233);
      add(1, 1, 24'hAABBCC, 1, 1, 32'h88994455);
      add(1, 0, 24'h000000, 1, 1, 32'hAABBCC77);
      add(1, 0, 24'h000000, 1, 0, 32'h0);
   endtask

   initial begin
      int pushes;

      do_reset(2);

      // Reset held with valid_in toggling, then idle, packing, mid-line reset
      for (int k = 0; k < 5; k++) add(0, (k % 2) == 0, 24'hABCDEF, 1, 0, 32'h0);
      add(1, 0, 24'h0, 1, 0, 32'h0);
      add(1, 0, 24'h0, 1, 0, 32'h0);
      add_pack_rows();
      add(1, 1, 24'h111111, 1, 0, 32'h0);
      add(1, 1, 24'h222222, 1, 0, 32'h0);
      add(0, 0, 24'h0,      1, 1, 32'h22111111);
      add(1, 0, 24'h0,      1, 0, 32'h0);
      add_pack_rows();

      foreach (tbl[k]) begin
         drive(tbl[k].rst_n, tbl[k].v, tbl[k].d, tbl[k].rdy, tbl[k].clr);
         chk($sformatf("tbl%0d m_valid", k),   m_valid,   tbl[k].e_valid);
         chk($sformatf("tbl%0d m_data", k),    m_data,    tbl[k].e_data);
         chk($sformatf("tbl%0d m_last", k),    m_last,    tbl[k].e_last);
         chk($sformatf("tbl%0d line_done", k), line_done, tbl[k].e_ldone);
         chk($sformatf("tbl%0d overflow", k),  overflow,  tbl[k].e_ovf);
         tick();
      end

      // Full line ramp with m_ready held high
      do_reset(1);
      for (int i = 0; i < LINE_LEN; i++) expect_sample(24'(i));
      for (int i = 0; i < LINE_LEN; i++) begin
         drive(1, 1, 24'(i), 1, 0);
         observe("line");
         chk($sformatf("line_done s%0d", i), line_done, i == LINE_LEN - 1);
         tick();
      end
      for (int c = 0; c < 8; c++) begin
         drive(1, 0, 24'h0, 1, 0);
         observe("line");
         chk("line_done idle", line_done, 1'b0);
         tick();
      end
      chk("line word count", got_words, WPL);
      chk("line overflow", overflow, 1'b0);

      // Stall with FIFO overrun: 24 samples make 18 pushes, and only 16 survive
      do_reset(1);
      for (int i = 0; i < 24; i++) expect_sample(samp(i));
      while (exp_w.size() > FIFO_DEPTH) begin
         void'(exp_w.pop_back());
         void'(exp_l.pop_back());
      end
      pushes = 0;
      for (int i = 0; i < 24; i++) begin
         drive(1, 1, samp(i), 0, 0);
         chk($sformatf("ovf s%0d overflow", i), overflow, pushes >= FIFO_DEPTH + 1);
         chk($sformatf("ovf s%0d m_valid", i), m_valid, pushes >= 1);
         if (pushes >= 1) chk($sformatf("ovf s%0d stable", i), m_data, exp_w[0]);
         if ((i % 4) != 0) pushes++;
         tick();
      end
      drive(1, 0, 24'h0, 0, 0);
      chk("ovf after stall", overflow, 1'b1);
      for (int c = 0; c < 24; c++) begin
         drive(1, 0, 24'h0, 1, 0);
         observe("ovf drain");
         tick();
      end
      chk("ovf drain count", got_words, FIFO_DEPTH);
      chk("ovf drained m_valid", m_valid, 1'b0);
      chk("ovf held", overflow, 1'b1);
      drive(1, 0, 24'h0, 1, 1);
      tick();
      drive(1, 0, 24'h0, 1, 0);
      chk("ovf cleared", overflow, 1'b0);

      // Push while full, with a pop in the same cycle
      do_reset(1);
      for (int i = 0; i < 24; i++) expect_sample(samp(i + 40));
      for (int i = 0; i < 24; i++) begin
         drive(1, 1, samp(i + 40), i >= 22, 0);
         observe("pp");
         tick();
         chk($sformatf("pp s%0d overflow", i), overflow, 1'b0);
      end
      for (int c = 0; c < 24; c++) begin
         drive(1, 0, 24'h0, 1, 0);
         observe("pp drain");
         tick();
      end
      chk("pp word count", got_words, 18);
      chk("pp overflow", overflow, 1'b0);

      // An overflow event in the same cycle as clr_ovf still sets the flag
      do_reset(1);
      for (int i = 0; i < 22; i++) begin
         drive(1, 1, samp(i), 0, 0);
         tick();
      end
      chk("setwins before", overflow, 1'b0);
      drive(1, 1, samp(22), 0, 1);
      tick();
      drive(1, 0, 24'h0, 0, 1);
      chk("setwins set", overflow, 1'b1);
      tick();
      drive(1, 0, 24'h0, 0, 0);
      chk("setwins clear", overflow, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
